// File: rtl/serial_digit_rx.sv
// Digit serial link receiver: oversamples sclk/data_enable/sdo, deserialises MSB-first frames
// into a word and scans that word onto a multiplexed hex 7-segment display.
module serial_digit_rx #(
    parameter int unsigned WORD_BITS = 32,
    parameter int unsigned SCAN_DIV  = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sclk,
    input  logic                   data_enable,
    input  logic                   sdo,
    output logic [WORD_BITS-1:0]   word,
    output logic                   word_valid,
    output logic                   frame_err,
    output logic [WORD_BITS/4-1:0] digit_sel,
    output logic [6:0]             segments
);

    localparam int unsigned DIGITS = WORD_BITS / 4;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
    localparam int unsigned BC_W   = $clog2(WORD_BITS + 2);

    localparam logic [BC_W-1:0]  BIT_FULL = BC_W'(WORD_BITS);
    localparam logic [BC_W-1:0]  BIT_OVR  = BC_W'(WORD_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StShift, StCheck} state_t;

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Bit order in the sync vectors: {sdo, data_enable, sclk}
    logic [2:0] sync1, sync2, prev;
    logic [1:0] settle;
    logic       armed, sclk_rise, en_rise, en_fall, sdo_s;

    state_t               state;
    logic [WORD_BITS-1:0] shreg;
    logic [BC_W-1:0]      bit_cnt;

    logic [CNT_W-1:0]  scan_cnt, scan_cnt_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [DIGITS-1:0] digit_sel_next;

    // Edges are blanked until the synchroniser and prev stage hold real samples after reset,
    // so an enable already high at reset release does not look like a rise.
    assign armed     = (settle == 2'd3);
    assign sclk_rise = armed & sync2[0] & ~prev[0];
    assign en_rise   = armed & sync2[1] & ~prev[1];
    assign en_fall   = armed & ~sync2[1] & prev[1];
    assign sdo_s     = sync2[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            prev   <= '0;
            settle <= '0;
        end else begin
            sync1 <= {sdo, data_enable, sclk};
            sync2 <= sync1;
            prev  <= sync2;
            if (!armed) settle <= settle + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            shreg      <= '0;
            bit_cnt    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                StIdle: begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                    if (en_rise) begin
                        state <= StShift;
                        if (sclk_rise) begin
                            shreg   <= {{(WORD_BITS-1){1'b0}}, sdo_s};
                            bit_cnt <= BC_W'(1);
                        end
                    end
                end
                StShift: begin
                    if (sclk_rise) begin
                        shreg <= {shreg[WORD_BITS-2:0], sdo_s};
                        if (bit_cnt != BIT_OVR) bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (en_fall) state <= StCheck;
                end
                default: begin
                    if (bit_cnt == BIT_FULL) begin
                        word       <= shreg;
                        word_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    bit_cnt <= '0;
                    state   <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        scan_cnt_next  = scan_cnt + 1'b1;
        idx_next       = idx;
        digit_sel_next = '0;
        if (scan_cnt == CNT_LAST) begin
            scan_cnt_next = '0;
            idx_next      = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        digit_sel_next[idx_next] = 1'b1;
    end

    // Segments follow the next index so the pattern and digit_sel switch on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            idx       <= '0;
            digit_sel <= DIGITS'(1);
            segments  <= 7'h3F;
        end else begin
            scan_cnt  <= scan_cnt_next;
            idx       <= idx_next;
            digit_sel <= digit_sel_next;
            segments  <= hex_seg(word[{idx_next, 2'b00} +: 4]);
        end
    end

endmodule
